// File: rtl/ps2_kb_led_ctrl.sv
// PS/2 keyboard LED writer: issues 0xED <led> through the shared transceiver,
// handles ack/resend/timeout, and forwards non-reply bytes to the key-code FSM.
module ps2_kb_led_ctrl #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_led_req,
  input  logic [2:0] i_led_val,
  output logic       o_busy,
  output logic       o_done_tick,
  output logic       o_err_tick,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_idle,
  input  logic       i_rx_done_tick,
  input  logic [7:0] i_rx_data,
  output logic       o_scan_done_tick,
  output logic [7:0] o_scan_code
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_MAX  = CW'(MAX_RETRY);
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    SEND_CMD     = 3'd1,
    WAIT_CMD_ACK = 3'd2,
    SEND_ARG     = 3'd3,
    WAIT_ARG_ACK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic [2:0]      pend_val_q, pend_val_d;
  logic [2:0]      led_q, led_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   count_q, count_d;

  logic rx_ack_s, rx_resend_s, timeout_s, in_wait_s, retry_s;

  assign rx_ack_s    = i_rx_done_tick && (i_rx_data == RSP_ACK);
  assign rx_resend_s = i_rx_done_tick && (i_rx_data == RSP_RESEND);
  assign timeout_s   = (timer_q == TIMER_LAST);
  assign in_wait_s   = (state_q == WAIT_CMD_ACK) || (state_q == WAIT_ARG_ACK);

  // State register and datapath flops.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_val_q <= 3'b000;
      led_q      <= 3'b000;
      timer_q    <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      led_q      <= led_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic, transceiver strobes and completion ticks.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    led_d       = led_q;
    timer_d     = timer_q;
    count_d     = count_q;
    retry_s     = 1'b0;
    o_tx_wr     = 1'b0;
    o_tx_data   = 8'h00;
    o_done_tick = 1'b0;
    o_err_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_q) begin
          led_d   = pend_val_q;
          pend_d  = 1'b0;
          count_d = '0;
          state_d = SEND_CMD;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_CMD: begin
        o_tx_data = CMD_SET_LED;
        if (i_tx_idle) begin
          o_tx_wr = 1'b1;
          timer_d = '0;
          state_d = WAIT_CMD_ACK;
        end else begin
          state_d = SEND_CMD;
        end
      end
      WAIT_CMD_ACK: begin
        o_tx_data = CMD_SET_LED;
        timer_d   = timer_q + TW'(1);
        // Ack is tested first so it beats a coincident timeout.
        if (rx_ack_s) begin
          state_d = SEND_ARG;
        end else if (rx_resend_s || timeout_s) begin
          retry_s = 1'b1;
        end else begin
          state_d = WAIT_CMD_ACK;
        end
      end
      SEND_ARG: begin
        o_tx_data = {5'b00000, led_q};
        if (i_tx_idle) begin
          o_tx_wr = 1'b1;
          timer_d = '0;
          state_d = WAIT_ARG_ACK;
        end else begin
          state_d = SEND_ARG;
        end
      end
      WAIT_ARG_ACK: begin
        o_tx_data = {5'b00000, led_q};
        timer_d   = timer_q + TW'(1);
        if (rx_ack_s) begin
          o_done_tick = 1'b1;
          state_d     = IDLE;
        end else if (rx_resend_s || timeout_s) begin
          retry_s = 1'b1;
        end else begin
          state_d = WAIT_ARG_ACK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A failed byte restarts the whole two-byte sequence.
    if (retry_s) begin
      if (count_q < RETRY_MAX) begin
        count_d = count_q + CW'(1);
        state_d = SEND_CMD;
      end else begin
        o_err_tick = 1'b1;
        state_d    = IDLE;
      end
    end else begin
      count_d = count_d;
    end

    // Placed last so a request in the launch cycle stays pending.
    if (i_led_req) begin
      pend_d     = 1'b1;
      pend_val_d = i_led_val;
    end else begin
      pend_val_d = pend_val_d;
    end
  end

  assign o_busy           = (state_q != IDLE);
  assign o_scan_code      = i_rx_data;
  assign o_scan_done_tick = i_rx_done_tick &&
                            !(in_wait_s && ((i_rx_data == RSP_ACK) || (i_rx_data == RSP_RESEND)));

endmodule

// File: doc/ps2_kb_led_ctrl.md
# ps2_kb_led_ctrl

Host-side command sequencer for the PS/2 keyboard path: it writes the keyboard LED state (Scroll/Num/Caps) by issuing the two-byte `0xED <led>` command through the shared PS/2 transceiver. Acknowledgement, resend and timeout handling are built in. It sits between the PS/2 transceiver and the key-code framing FSM. Device replies (`0xFA`/`0xFE`) are consumed during a transaction; all other received bytes pass through to the key-code logic unchanged.

## Interface
- `TIMEOUT_CYCLES`, default 2_500_000: ack wait limit in i_clk cycles (25 ms at 100 MHz); timer width `$clog2(TIMEOUT_CYCLES)`.
- `MAX_RETRY`, default 3: retries allowed after the first attempt before error; counter width `$clog2(MAX_RETRY+1)`.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_led_req`  in  1  one-cycle request to write LEDs.
- `i_led_val`  in  3  {caps, num, scroll}; sampled when `i_led_req`=1.
- `o_busy`  out  1  transaction in progress (state != IDLE).
- `o_done_tick`  out  1  one-cycle pulse: LED byte acknowledged.
- `o_err_tick`  out  1  one-cycle pulse: retries exhausted.
- `o_tx_wr`  out  1  one-cycle write strobe to transceiver.
- `o_tx_data`  out  8  byte to transmit.
- `i_tx_idle`  in  1  transceiver ready to accept a byte.
- `i_rx_done_tick`  in  1  transceiver received a byte.
- `i_rx_data`  in  8  received byte.
- `o_scan_done_tick`  out  1  filtered receive strobe to the key-code FSM.
- `o_scan_code`  out  8  filtered receive data (= `i_rx_data`).

## Operation
- Request capture: `i_led_req` sets `pend`=1 and loads `i_led_val` into `pend_val` in any state. A later request overwrites an earlier one (last value wins).
- States: IDLE, SEND_CMD, WAIT_CMD_ACK, SEND_ARG, WAIT_ARG_ACK.
- IDLE: if `pend`, copy `pend_val`→`led_reg`, clear `pend`, clear retry count, go to SEND_CMD. A request arriving in the same cycle as the transition is kept pending (not merged into the current transaction).
- SEND_CMD: when `i_tx_idle`=1, assert `o_tx_wr` with `o_tx_data`=0xED; clear timer; go to WAIT_CMD_ACK. Otherwise hold.
- WAIT_CMD_ACK: `i_rx_done_tick` with 0xFA → SEND_ARG. 0xFE, or timer == TIMEOUT_CYCLES-1 → retry path.
- SEND_ARG: when `i_tx_idle`=1, assert `o_tx_wr` with `o_tx_data`={5'b0, `led_reg`}; clear timer; go to WAIT_ARG_ACK.
- WAIT_ARG_ACK: 0xFA → `o_done_tick`=1, go to IDLE. 0xFE or timeout → retry path.
- Retry path (both WAIT states): if count < MAX_RETRY, increment count and go to SEND_CMD (the full sequence restarts). Otherwise pulse `o_err_tick` and go to IDLE. `led_reg` is discarded; `pend` is unaffected.
- Timer: counts +1 per cycle in WAIT states only; reset to 0 on entering a WAIT state.
- `o_tx_data`: 0xED in SEND_CMD/WAIT_CMD_ACK, {5'b0,`led_reg`} in SEND_ARG/WAIT_ARG_ACK, 0x00 in IDLE.
- Receive filter: `o_scan_code`=`i_rx_data` always. `o_scan_done_tick`=`i_rx_done_tick`, except in WAIT states when the data is 0xFA or 0xFE; then it is 0. Any other byte in WAIT states (e.g. a scan code) passes through and does not affect the FSM.

## Timing
- Reset (async): state IDLE, `pend`=0, `pend_val`=0, `led_reg`=0, timer=0, count=0. All outputs 0, `o_tx_data`=0x00.
- `o_tx_wr`, `o_done_tick`, `o_err_tick`, `o_scan_done_tick` are combinational from state and inputs. Each is high for exactly the one cycle of its qualifying condition.
- Request to first `o_tx_wr`: 2 cycles minimum (IDLE→SEND_CMD, then write if `i_tx_idle`).
- Ack to next `o_tx_wr`: 1 cycle (WAIT_CMD_ACK→SEND_ARG, write when `i_tx_idle`).
- Ack and timeout in the same cycle: the ack wins.
- Timeout fires on cycle TIMEOUT_CYCLES-1 after WAIT entry (entry cycle = 0).
- Reset mid-transaction aborts immediately with no tick outputs. Any transceiver byte already strobed completes outside this block's control.

## Test plan
- Nominal: `i_led_val`=3'b101, `i_tx_idle`=1, reply FA after each write. Expect `o_tx_wr` with 0xED, then 0x05; `o_done_tick` once; `o_busy` low after; no `o_scan_done_tick` for either FA.
- Resend: reply FE to the 0x05 byte, then FA/FA. Expect sequence 0xED, 0x05, 0xED, 0x05, then `o_done_tick`; FE suppressed.
- Timeout/error (TIMEOUT_CYCLES=100, MAX_RETRY=2): no replies. Expect exactly 3 writes of 0xED spaced 101 cycles apart (100 wait cycles + 1 SEND cycle), then `o_err_tick` and IDLE.
- Passthrough: inject 0x1C, F0, 0x1C during WAIT_CMD_ACK. All three appear on `o_scan_done_tick`/`o_scan_code`; state unchanged; a following FA advances to SEND_ARG.
- Overlap: request 3'b001 then 3'b010 and 3'b100 while busy. Expect the first transaction with 0x01, then exactly one more with 0x04.
- Reset: assert `i_reset` in WAIT_ARG_ACK. Outputs 0 immediately; a later FA produces `o_scan_done_tick`=1 and no `o_done_tick`.
